// File: rtl/mode_key_ctrl_if.sv
// Key/mode bundle between the pushbutton front end and its consumers.
//   KEY        raw active-low pushbuttons (1 = released)
//   MODE       registered two-bit ALU mode select
//   MODE_STB   one-cycle pulse in the cycle MODE takes a new value
//   PRESS      per-key one-cycle pulse on each accepted press
//   KEY_STABLE debounced key level, active-low
// master: the board/stimulus side that drives KEY and observes the results.
// slave:  the mode_key_ctrl block itself.
interface mode_key_ctrl_if;
  logic [1:0] KEY;
  logic [1:0] MODE;
  logic       MODE_STB;
  logic [1:0] PRESS;
  logic [1:0] KEY_STABLE;

  modport master (
    output KEY,
    input  MODE,
    input  MODE_STB,
    input  PRESS,
    input  KEY_STABLE
  );

  modport slave (
    input  KEY,
    output MODE,
    output MODE_STB,
    output PRESS,
    output KEY_STABLE
  );
endinterface

// File: rtl/mode_key_ctrl.sv
// Pushbutton front end for the ALU mode select.
// Each of the two raw keys is synchronised (2 FF), debounced (a level change must hold for
// DEBOUNCE_CYCLES consecutive cycles) and edge-detected. An accepted press (stable 1->0)
// toggles the matching MODE bit. Releases only update KEY_STABLE.
// Ports:
//   CLOCK_50  system clock, rising edge
//   RESET_N   asynchronous active-low reset
//   bus       mode_key_ctrl_if.slave: KEY in; MODE, MODE_STB, PRESS, KEY_STABLE out
// Every output comes straight from a flop; there is no combinational path from KEY.
module mode_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  mode_key_ctrl_if.slave        bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Per-lane state
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  // Mode register and strobes
  logic [1:0] mode_q, mode_d;
  logic [1:0] press_q, press_d;
  logic       stb_q, stb_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        // Back at (or still at) the accepted level: any partial count is discarded.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        // Only the 1->0 (press) direction is reported.
        press_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Press, toggle and strobe are all registered on the acceptance edge so they line up.
    mode_d = mode_q ^ press_d;
    stb_d  = |press_d;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stable_q <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      mode_q   <= 2'b00;
      press_q  <= 2'b00;
      stb_q    <= 1'b0;
    end else begin
      sync1_q  <= bus.KEY;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      mode_q   <= mode_d;
      press_q  <= press_d;
      stb_q    <= stb_d;
    end
  end

  assign bus.MODE       = mode_q;
  assign bus.MODE_STB   = stb_q;
  assign bus.PRESS      = press_q;
  assign bus.KEY_STABLE = stable_q;

endmodule

// File: tb/tb_mode_key_ctrl.sv
// Directed bench for mode_key_ctrl with DEBOUNCE_CYCLES=4, CNT_W=3.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_mode_key_ctrl;

  logic CLOCK_50;
  logic RESET_N;
  mode_key_ctrl_if bus ();

  mode_key_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  int stb_cnt  = 0;
  int s0;

  // Strobe pulses counted mid-cycle, well away from the active edge.
  always @(negedge CLOCK_50) begin
    if (bus.MODE_STB === 1'b1) stb_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    bus.KEY = 2'b11;
    RESET_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
  endtask

  // Drop the keys given by 'pattern' (active-low), expect acceptance at edge 5, then release.
  task automatic press_keys(input string tag, input logic [1:0] pattern,
                            input logic [1:0] exp_mode, input logic [1:0] exp_press);
    int base;
    base = stb_cnt;
    bus.KEY = pattern;
    tick(5);
    check_eq({tag, "_pre_stb"}, 32'(bus.MODE_STB), 32'd0);
    tick(1);
    check_eq({tag, "_mode"}, 32'(bus.MODE), 32'(exp_mode));
    check_eq({tag, "_press"}, 32'(bus.PRESS), 32'(exp_press));
    check_eq({tag, "_stb"}, 32'(bus.MODE_STB), 32'd1);
    tick(1);
    check_eq({tag, "_stb_drop"}, 32'(bus.MODE_STB), 32'd0);
    check_eq({tag, "_press_drop"}, 32'(bus.PRESS), 32'd0);
    bus.KEY = 2'b11;
    tick(8);
    check_eq({tag, "_hold_mode"}, 32'(bus.MODE), 32'(exp_mode));
    check_eq({tag, "_stb_count"}, 32'(stb_cnt - base), 32'd1);
  endtask

  initial begin
    RESET_N = 1'b1;
    bus.KEY = 2'b11;
    tick(2);

    // Asynchronous reset mid-cycle: outputs settle without a clock edge.
    #3;
    RESET_N = 1'b0;
    #1;
    check_eq("rst_mode", 32'(bus.MODE), 32'd0);
    check_eq("rst_stable", 32'(bus.KEY_STABLE), 32'd3);
    check_eq("rst_stb", 32'(bus.MODE_STB), 32'd0);
    check_eq("rst_press", 32'(bus.PRESS), 32'd0);
    tick(2);
    RESET_N = 1'b1;

    // Clean press on KEY0, held 20 cycles then released.
    s0 = stb_cnt;
    bus.KEY = 2'b10;
    tick(5);
    check_eq("clean_pre_mode", 32'(bus.MODE), 32'd0);
    check_eq("clean_pre_press", 32'(bus.PRESS), 32'd0);
    tick(1);
    check_eq("clean_mode", 32'(bus.MODE), 32'd1);
    check_eq("clean_press", 32'(bus.PRESS), 32'd1);
    check_eq("clean_stb", 32'(bus.MODE_STB), 32'd1);
    check_eq("clean_stable", 32'(bus.KEY_STABLE), 32'd2);
    tick(1);
    check_eq("clean_stb_drop", 32'(bus.MODE_STB), 32'd0);
    tick(13);
    check_eq("clean_held_mode", 32'(bus.MODE), 32'd1);
    check_eq("clean_held_stb_count", 32'(stb_cnt - s0), 32'd1);
    bus.KEY = 2'b11;
    tick(10);
    check_eq("release_mode", 32'(bus.MODE), 32'd1);
    check_eq("release_stable", 32'(bus.KEY_STABLE), 32'd3);
    check_eq("release_stb_count", 32'(stb_cnt - s0), 32'd1);

    // Bounce on KEY1 from MODE=00: short lows never reach the threshold.
    do_reset();
    s0 = stb_cnt;
    for (int b = 0; b < 2; b++) begin
      bus.KEY = 2'b01;
      tick(2);
      bus.KEY = 2'b11;
      tick(2);
    end
    bus.KEY = 2'b01;
    tick(5);
    check_eq("bounce_pre_stb_count", 32'(stb_cnt - s0), 32'd0);
    check_eq("bounce_pre_mode", 32'(bus.MODE), 32'd0);
    tick(1);
    check_eq("bounce_mode", 32'(bus.MODE), 32'd2);
    check_eq("bounce_press", 32'(bus.PRESS), 32'd2);
    check_eq("bounce_stb", 32'(bus.MODE_STB), 32'd1);
    bus.KEY = 2'b11;
    tick(8);
    check_eq("bounce_stb_count", 32'(stb_cnt - s0), 32'd1);

    // Simultaneous presses: 00 -> 11 -> 00 with a single strobe each.
    do_reset();
    press_keys("sim1", 2'b00, 2'b11, 2'b11);
    press_keys("sim2", 2'b00, 2'b00, 2'b11);

    // Sequence wrap: KEY0, KEY1, KEY0, KEY1.
    do_reset();
    press_keys("seq1", 2'b10, 2'b01, 2'b01);
    press_keys("seq2", 2'b01, 2'b11, 2'b10);
    press_keys("seq3", 2'b10, 2'b10, 2'b01);
    press_keys("seq4", 2'b01, 2'b00, 2'b10);

    // Reset mid-debounce: partial count lost, held key re-accepted from scratch.
    do_reset();
    press_keys("pre_mid", 2'b10, 2'b01, 2'b01);
    bus.KEY = 2'b10;
    tick(2);
    RESET_N = 1'b0;
    #1;
    check_eq("mid_rst_mode", 32'(bus.MODE), 32'd0);
    tick(2);
    check_eq("mid_rst_hold_mode", 32'(bus.MODE), 32'd0);
    RESET_N = 1'b1;
    // First edge after release samples the held key (edge 0); acceptance at edge 5.
    tick(5);
    check_eq("mid_rel_pre_mode", 32'(bus.MODE), 32'd0);
    tick(1);
    check_eq("mid_rel_mode", 32'(bus.MODE), 32'd1);
    check_eq("mid_rel_stb", 32'(bus.MODE_STB), 32'd1);
    bus.KEY = 2'b11;
    tick(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
